stop_watch_ctrl: RTL

//  Run/stop/lap/clear sequencer for the stopwatch counter chain (usec 00-99, sec 00-59, min 00-59).
//  - Gates the 100 Hz pulse into the counter's plsi; the counter advances on the falling edge of plsi.
//  - Generates the counter's clr; the counter clears on the rising edge of clr.
//  - Holds a lap snapshot so the display can freeze while counting continues.
//  - Sits between the button debouncers/100 Hz prescaler and the counter plus 7-seg display path.

---
 rtl/stop_watch_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/stop_watch_ctrl.sv
// Stopwatch sequencer: turns debounced run/lap buttons into run/stop/lap/clear control,
// gates the 100 Hz pulse into the counter and drives the frozen or live display value.
module stop_watch_ctrl #(
    parameter int CLR_CYCLES = 2,
    parameter int USEC_W     = 7,
    parameter int SEC_W      = 6,
    parameter int MIN_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_run,
    input  logic              btn_lap,
    input  logic              pls_100hz,
    input  logic [USEC_W-1:0] i_usec,
    input  logic [SEC_W-1:0]  i_sec,
    input  logic [MIN_W-1:0]  i_min,
    output logic              o_plsi,
    output logic              o_clr,
    output logic [USEC_W-1:0] o_usec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [2:0]        o_state
);

    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STOP = 3'd2,
        S_LAP  = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    state_t            state_q;
    logic              btn_run_q;
    logic              btn_lap_q;
    logic              gate_q;
    logic              plsi_q;
    logic              clr_q;
    logic [CW-1:0]     clr_cnt_q;
    logic [USEC_W-1:0] lap_usec_q;
    logic [SEC_W-1:0]  lap_sec_q;
    logic [MIN_W-1:0]  lap_min_q;
    logic [USEC_W-1:0] usec_q;
    logic [SEC_W-1:0]  sec_q;
    logic [MIN_W-1:0]  min_q;

    logic run_ev;
    logic lap_ev;
    logic run_gate;

    // A run edge suppresses a coincident lap edge.
    assign run_ev   = btn_run & ~btn_run_q;
    assign lap_ev   = btn_lap & ~btn_lap_q & ~run_ev;
    assign run_gate = (state_q == S_RUN) || (state_q == S_LAP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            btn_run_q  <= 1'b0;
            btn_lap_q  <= 1'b0;
            gate_q     <= 1'b0;
            plsi_q     <= 1'b0;
            clr_q      <= 1'b0;
            clr_cnt_q  <= '0;
            lap_usec_q <= '0;
            lap_sec_q  <= '0;
            lap_min_q  <= '0;
            usec_q     <= '0;
            sec_q      <= '0;
            min_q      <= '0;
        end else begin
            btn_run_q <= btn_run;
            btn_lap_q <= btn_lap;
            // Gate only moves between pulses so a pulse in flight is passed or blocked whole.
            if (!pls_100hz) begin
                gate_q <= run_gate;
            end
            plsi_q <= pls_100hz & gate_q;
            clr_q  <= 1'b0;

            if (state_q == S_LAP) begin
                usec_q <= lap_usec_q;
                sec_q  <= lap_sec_q;
                min_q  <= lap_min_q;
            end else begin
                usec_q <= i_usec;
                sec_q  <= i_sec;
                min_q  <= i_min;
            end

            case (state_q)
                S_IDLE: begin
                    if (run_ev) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (run_ev) begin
                        state_q <= S_STOP;
                    end else if (lap_ev) begin
                        state_q    <= S_LAP;
                        lap_usec_q <= i_usec;
                        lap_sec_q  <= i_sec;
                        lap_min_q  <= i_min;
                    end
                end
                S_LAP: begin
                    if (run_ev || lap_ev) begin
                        state_q <= run_ev ? S_STOP : S_RUN;
                        usec_q  <= i_usec;
                        sec_q   <= i_sec;
                        min_q   <= i_min;
                    end
                end
                S_STOP: begin
                    if (run_ev) begin
                        state_q <= S_RUN;
                    end else if (lap_ev) begin
                        state_q   <= S_CLR;
                        clr_cnt_q <= CW'(CLR_CYCLES - 1);
                        clr_q     <= 1'b1;
                    end
                end
                S_CLR: begin
                    lap_usec_q <= '0;
                    lap_sec_q  <= '0;
                    lap_min_q  <= '0;
                    if (clr_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_q - CW'(1);
                        clr_q     <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_plsi  = plsi_q;
    assign o_clr   = clr_q;
    assign o_usec  = usec_q;
    assign o_sec   = sec_q;
    assign o_min   = min_q;
    assign o_state = state_q;

endmodule
